ibex_instr_req_ctrl: RTL and testbench

- Request side of the instruction prefetch path. Issues word-aligned requests on the instruction bus and tracks up to NUM_REQS outstanding responses.
- Discards responses that belong to requests made before a branch.
- Forwards surviving responses (addr, rdata, err) to the downstream fetch FIFO, which owns alignment and compressed-instruction handling.
- Throttles issue using the FIFO busy vector so that every granted request has a FIFO slot reserved.

---
 rtl/ibex_instr_req_ctrl_pkg.sv | 21 ++
 rtl/ibex_instr_req_ctrl_if.sv | 44 ++++
 rtl/ibex_instr_req_ctrl.sv | 112 +++++++++++
 tb/tb_ibex_instr_req_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_instr_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_req_ctrl_pkg
// Description : Types and constants shared by the instruction request
//               controller and the downstream fetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_instr_req_ctrl_pkg;

    localparam int unsigned NUM_REQS_DEFAULT = 2;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef struct packed {
        logic outstanding;
        logic discard;
        logic pmp;
    } req_slot_t;

endpackage
`default_nettype wire

// File: rtl/ibex_instr_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_req_ctrl_if
// Description : Instruction bus and fetch-FIFO signals of the request
//               controller. master = controller side, slave = bus/FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_instr_req_ctrl_if
    import ibex_instr_req_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQS = NUM_REQS_DEFAULT
);

    logic                instr_req_o;
    logic                instr_gnt_i;
    logic [31:0]         instr_addr_o;
    logic                instr_rvalid_i;
    logic [31:0]         instr_rdata_i;
    logic                instr_err_i;
    logic                instr_pmp_err_i;

    logic [NUM_REQS-1:0] fifo_busy_i;
    logic                fifo_clear_o;
    logic                fifo_valid_o;
    logic [31:0]         fifo_addr_o;
    logic [31:0]         fifo_rdata_o;
    logic                fifo_err_o;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i, instr_pmp_err_i,
        input  fifo_busy_i,
        output fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i, instr_pmp_err_i,
        output fifo_busy_i,
        input  fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o
    );

endinterface
`default_nettype wire

// File: rtl/ibex_instr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_req_ctrl
// Description : Prefetch request side - issues word-aligned bus requests,
//               tracks outstanding responses and forwards survivors to the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_req_ctrl
    import ibex_instr_req_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQS = NUM_REQS_DEFAULT
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              req_i,
    input  wire logic              branch_i,
    input  wire logic [31:0]       addr_i,
    output logic                   busy_o,
    ibex_instr_req_ctrl_if.master  bus
);

    req_slot_t [NUM_REQS-1:0] r_slots;
    req_slot_t [NUM_REQS-1:0] w_slots_d;
    req_slot_t [NUM_REQS-1:0] w_slots_next;
    logic [NUM_REQS-1:0]      w_out;
    logic [NUM_REQS-1:0]      w_out_rev;
    logic [NUM_REQS-1:0]      w_alloc;

    logic        r_hold;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_stored_addr;
    logic [31:0] w_req_addr;
    logic        w_fifo_ready;
    logic        w_valid_new_req;
    logic        w_req;
    logic        w_accept;
    logic        w_retire;

    // Slot 0 is the oldest; a retirement shifts every slot down by one.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
        assign w_out[i]     = r_slots[i].outstanding;
        assign w_out_rev[i] = r_slots[NUM_REQS-1-i].outstanding;

        if (i == 0) begin : g_first
            assign w_alloc[i] = w_accept & ~w_out[0];
        end else begin : g_rest
            assign w_alloc[i] = w_accept & w_out[i-1] & ~w_out[i];
        end

        assign w_slots_d[i] = '{
            outstanding: w_out[i] | w_alloc[i],
            discard:     w_out[i] & (r_slots[i].discard | branch_i),
            pmp:         w_alloc[i] ? bus.instr_pmp_err_i : r_slots[i].pmp
        };

        if (i == NUM_REQS-1) begin : g_top
            assign w_slots_next[i] = w_retire ? req_slot_t'('0) : w_slots_d[i];
        end else begin : g_shift
            assign w_slots_next[i] = w_retire ? w_slots_d[i+1] : w_slots_d[i];
        end
    end

    // Reserve a FIFO entry for every request that may still be in flight.
    assign w_fifo_ready    = ~&(bus.fifo_busy_i | w_out_rev);
    assign w_valid_new_req = rst_ni & req_i & (w_fifo_ready | branch_i) & ~w_out[NUM_REQS-1];
    assign w_req           = w_valid_new_req | r_hold;
    assign w_accept        = w_req & (bus.instr_gnt_i | bus.instr_pmp_err_i);
    assign w_retire        = r_slots[0].outstanding & (r_slots[0].pmp | bus.instr_rvalid_i);

    always_comb begin
        w_req_addr = r_fetch_addr;
        if (branch_i) begin
            w_req_addr = addr_i & WORD_ALIGN_MASK;
        end else if (r_hold) begin
            w_req_addr = r_stored_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slots       <= '0;
            r_hold        <= 1'b0;
            r_fetch_addr  <= '0;
            r_stored_addr <= '0;
        end else begin
            r_slots <= w_slots_next;
            if (w_req && !w_accept) begin
                r_hold        <= 1'b1;
                r_stored_addr <= w_req_addr;
            end else begin
                r_hold        <= 1'b0;
            end
            // An unaccepted branch parks on the target so the redirect is issued later.
            if (w_accept) begin
                r_fetch_addr <= w_req_addr + WORD_BYTES;
            end else if (branch_i) begin
                r_fetch_addr <= w_req_addr;
            end
        end
    end

    assign bus.instr_req_o  = w_req;
    assign bus.instr_addr_o = w_req_addr;
    assign bus.fifo_clear_o = branch_i;
    assign bus.fifo_valid_o = w_retire & ~r_slots[0].discard;
    assign bus.fifo_addr_o  = addr_i;
    assign bus.fifo_rdata_o = bus.instr_rdata_i;
    assign bus.fifo_err_o   = bus.instr_err_i | r_slots[0].pmp;
    assign busy_o           = (|w_out) | w_req;

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_instr_req_ctrl
// Description : Directed bench for ibex_instr_req_ctrl with a queue-based
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_req_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        busy_o;

    ibex_instr_req_ctrl_if #(.NUM_REQS(N)) bus ();

    ibex_instr_req_ctrl #(.NUM_REQS(N)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .branch_i (branch_i),
        .addr_i   (addr_i),
        .busy_o   (busy_o),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-flight requests as a FIFO queue, plus a held request.
    typedef struct { bit discard; bit pmp; } ent_t;
    ent_t        oq[$];
    bit          held = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] next_addr = '0;

    always @(negedge clk) begin : p_compare
        int          n;
        bit          all_cov, e_req, e_acc, e_ret, e_valid, e_err, e_busy;
        logic [31:0] e_addr;
        if (!rst_ni) begin
            oq.delete();
            held      = 1'b0;
            held_addr = '0;
            next_addr = '0;
        end
        n = oq.size();
        all_cov = 1'b1;
        for (int k = 0; k < N; k++)
            if (!(bus.fifo_busy_i[k] || (k >= N - n))) all_cov = 1'b0;
        e_req   = rst_ni && (held || (req_i && (!all_cov || branch_i) && n < N));
        e_addr  = branch_i ? (addr_i & 32'hFFFF_FFFC) : (held ? held_addr : next_addr);
        e_acc   = e_req && (bus.instr_gnt_i || bus.instr_pmp_err_i);
        e_ret   = (n > 0) && (oq[0].pmp || bus.instr_rvalid_i);
        e_valid = e_ret && !oq[0].discard;
        e_err   = bus.instr_err_i || ((n > 0) && oq[0].pmp);
        e_busy  = (n > 0) || e_req;

        chk("m_req",   bus.instr_req_o,  e_req);
        chk("m_busy",  busy_o,           e_busy);
        chk("m_valid", bus.fifo_valid_o, e_valid);
        chk("m_clear", bus.fifo_clear_o, branch_i);
        if (e_req)    chk("m_addr",  bus.instr_addr_o, e_addr);
        if (e_valid)  chk("m_rdata", bus.fifo_rdata_o, bus.instr_rdata_i);
        if (e_valid)  chk("m_err",   bus.fifo_err_o,   e_err);
        if (branch_i) chk("m_faddr", bus.fifo_addr_o,  addr_i);

        if (rst_ni) begin
            if (branch_i) foreach (oq[j]) oq[j].discard = 1'b1;
            if (e_ret) void'(oq.pop_front());
            if (e_acc) oq.push_back('{discard: 1'b0, pmp: bus.instr_pmp_err_i});
            held = e_req && !e_acc;
            if (held) held_addr = e_addr;
            if (e_acc)         next_addr = e_addr + 32'd4;
            else if (branch_i) next_addr = e_addr;
        end
    end

    task automatic step(input logic rq, input logic br, input logic [31:0] a,
                        input logic [N-1:0] bz, input logic g, input logic rv,
                        input logic [31:0] rd, input logic er, input logic pm);
        @(posedge clk);
        #1;
        req_i               = rq;
        branch_i            = br;
        addr_i              = a;
        bus.fifo_busy_i     = bz;
        bus.instr_gnt_i     = g;
        bus.instr_rvalid_i  = rv;
        bus.instr_rdata_i   = rd;
        bus.instr_err_i     = er;
        bus.instr_pmp_err_i = pm;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i = 1'b0; branch_i = 1'b0; addr_i = '0;
        bus.fifo_busy_i = '0; bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i = '0; bus.instr_err_i = 1'b0; bus.instr_pmp_err_i = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_req",   bus.instr_req_o,  1'b0);
        chk("rst_busy",  busy_o,           1'b0);
        chk("rst_valid", bus.fifo_valid_o, 1'b0);
        @(posedge clk); #1; rst_ni = 1'b1;

        // Back-to-back grants from 0x100
        step(1, 1, 32'h100, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("b2b_addr0", bus.instr_addr_o, 32'h100); chk("b2b_clear", bus.fifo_clear_o, 1'b1);
        step(1, 0, 32'h0,   2'b00, 1, 1, 32'hA0, 0, 0);
        chk("b2b_addr1", bus.instr_addr_o, 32'h104); chk("b2b_v1", bus.fifo_valid_o, 1'b1);
        chk("b2b_rd1", bus.fifo_rdata_o, 32'hA0);    chk("b2b_busy", busy_o, 1'b1);
        step(1, 0, 32'h0,   2'b00, 1, 1, 32'hA1, 0, 0);
        chk("b2b_addr2", bus.instr_addr_o, 32'h108); chk("b2b_v2", bus.fifo_valid_o, 1'b1);
        step(0, 0, 32'h0,   2'b00, 0, 1, 32'hA2, 0, 0);
        chk("b2b_v3", bus.fifo_valid_o, 1'b1); chk("b2b_req_off", bus.instr_req_o, 1'b0);
        step(0, 0, 32'h0,   2'b00, 0, 0, 32'h0,  0, 0);
        chk("idle_busy", busy_o, 1'b0);

        // Grant stall at 0x200 while req_i drops
        step(1, 1, 32'h200, 2'b00, 0, 0, 32'h0, 0, 0);
        chk("stall_addr0", bus.instr_addr_o, 32'h200);
        for (int s = 0; s < 2; s++) begin
            step(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0, 0);
            chk("stall_req",  bus.instr_req_o,  1'b1);
            chk("stall_addr", bus.instr_addr_o, 32'h200);
        end
        step(0, 0, 32'h0, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("stall_gnt_addr", bus.instr_addr_o, 32'h200);
        step(0, 0, 32'h0, 2'b00, 0, 1, 32'hB0, 0, 0);
        chk("stall_v", bus.fifo_valid_o, 1'b1); chk("stall_req_off", bus.instr_req_o, 1'b0);

        // Branch with both slots outstanding
        step(1, 0, 32'h0,    2'b00, 1, 0, 32'h0,  0, 0);
        chk("br_addr_a", bus.instr_addr_o, 32'h204);
        step(1, 0, 32'h0,    2'b00, 1, 0, 32'h0,  0, 0);
        chk("br_addr_b", bus.instr_addr_o, 32'h208);
        step(1, 1, 32'h1002, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("br_addr", bus.instr_addr_o, 32'h1000); chk("br_clear", bus.fifo_clear_o, 1'b1);
        chk("br_full_req", bus.instr_req_o, 1'b0);  chk("br_faddr", bus.fifo_addr_o, 32'h1002);
        step(1, 0, 32'h0,    2'b00, 1, 1, 32'hC0, 0, 0);
        chk("br_disc1", bus.fifo_valid_o, 1'b0);    chk("br_full_req2", bus.instr_req_o, 1'b0);
        step(1, 0, 32'h0,    2'b00, 1, 1, 32'hC1, 0, 0);
        chk("br_disc2", bus.fifo_valid_o, 1'b0);    chk("br_redirect", bus.instr_addr_o, 32'h1000);
        step(0, 0, 32'h0,    2'b00, 0, 1, 32'hC2, 0, 0);
        chk("br_keep", bus.fifo_valid_o, 1'b1);     chk("br_keep_rd", bus.fifo_rdata_o, 32'hC2);

        // FIFO throttle
        step(1, 0, 32'h0, 2'b11, 0, 0, 32'h0,  0, 0);
        chk("thr_full", bus.instr_req_o, 1'b0);
        step(1, 0, 32'h0, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("thr_free", bus.instr_req_o, 1'b1);     chk("thr_addr", bus.instr_addr_o, 32'h1004);
        step(1, 0, 32'h0, 2'b01, 0, 0, 32'h0,  0, 0);
        chk("thr_part", bus.instr_req_o, 1'b0);
        step(0, 0, 32'h0, 2'b00, 0, 1, 32'hD0, 0, 0);
        chk("thr_v", bus.fifo_valid_o, 1'b1);

        // PMP fault then bus error
        step(1, 1, 32'h300, 2'b00, 0, 0, 32'h0,  0, 1);
        chk("pmp_addr", bus.instr_addr_o, 32'h300);
        step(0, 0, 32'h0,   2'b00, 0, 0, 32'h0,  0, 0);
        chk("pmp_v", bus.fifo_valid_o, 1'b1);       chk("pmp_err", bus.fifo_err_o, 1'b1);
        step(1, 0, 32'h0,   2'b00, 0, 0, 32'h0,  0, 0);
        chk("pmp_next", bus.instr_addr_o, 32'h304);
        step(0, 0, 32'h0,   2'b00, 1, 0, 32'h0,  0, 0);
        chk("pmp_held", bus.instr_addr_o, 32'h304);
        step(0, 0, 32'h0,   2'b00, 0, 1, 32'hE0, 1, 0);
        chk("buserr_v", bus.fifo_valid_o, 1'b1);    chk("buserr_err", bus.fifo_err_o, 1'b1);

        // Address wrap, then two outstanding before reset
        step(1, 1, 32'hFFFF_FFFE, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("wrap_a", bus.instr_addr_o, 32'hFFFF_FFFC);
        step(1, 0, 32'h0, 2'b00, 1, 1, 32'hF0, 0, 0);
        chk("wrap_b", bus.instr_addr_o, 32'h0);
        step(1, 0, 32'h0, 2'b00, 1, 0, 32'h0,  0, 0);
        chk("wrap_c", bus.instr_addr_o, 32'h4);

        // Asynchronous reset mid-transaction
        @(posedge clk); #1;
        rst_ni = 1'b0; req_i = 1'b0; bus.instr_gnt_i = 1'b0;
        #1;
        chk("arst_req",  bus.instr_req_o, 1'b0);
        chk("arst_busy", busy_o,          1'b0);
        repeat (2) @(posedge clk);
        #1; rst_ni = 1'b1;
        step(0, 0, 32'h0, 2'b00, 0, 1, 32'h99, 0, 0);
        chk("stray_v", bus.fifo_valid_o, 1'b0);     chk("stray_busy", busy_o, 1'b0);
        step(0, 0, 32'h0, 2'b00, 0, 0, 32'h0,  0, 0);
        step(0, 0, 32'h0, 2'b00, 0, 0, 32'h0,  0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
